// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate sequencer: op codes,
// FSM state encoding and default sizing.
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step: one bit per call,
// zero fill for logical shifts, wrap-around for rotates.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = acc;
    case (op)
      OP_SLL:  nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  nxt = {1'b0, acc[WIDTH-1:1]};
      OP_ROL:  nxt = {acc[WIDTH-2:0], acc[WIDTH-1]};
      OP_ROR:  nxt = {acc[0], acc[WIDTH-1:1]};
      default: nxt = acc;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Handshaked iterative shifter: accepts {choice, i0, shift_by}, applies one
// bit step per clock, then presents the result until out_ready is seen.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       choice,
  input  logic [WIDTH-1:0] i0,
  input  logic [SHW-1:0]   shift_by,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on valid on either channel.
  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] step_nxt;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .acc (acc),
    .nxt (step_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_SLL;
      acc   <= '0;
      cnt   <= '0;
      o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= choice;
            acc  <= i0;
            cnt  <= shift_by;
            if (shift_by == '0) begin
              o     <= i0;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= step_nxt;
          cnt <= cnt - 1'b1;
          // The last step goes straight to o so DONE shows the final value.
          if (cnt == SHW'(1)) begin
            o     <= step_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed and random checks of shift_seq: reset values, per-op results,
// latency, backpressure, ignored inputs and asynchronous mid-shift reset.
module tb_shift_seq;
  import shift_pkg::*;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   choice = 2'b00;
  logic [W-1:0] i0 = '0;
  logic [S-1:0] shift_by = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] o;

  int vectors = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  shift_seq #(.WIDTH(W), .SHW(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .choice    (choice),
    .i0        (i0),
    .shift_by  (shift_by),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Whole-word reference built from barrel shifts, not bit steps.
  function automatic logic [W-1:0] model(logic [1:0] op, logic [W-1:0] a, int n);
    logic [W-1:0] r;
    case (op)
      OP_SLL:  r = a << n;
      OP_SRL:  r = a >> n;
      OP_ROL:  r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
      default: r = (n == 0) ? a : ((a >> n) | (a << (W - n)));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one command from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                      input logic [S-1:0] n, input logic [W-1:0] exp);
    int t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_cmd", W'(in_ready), W'(1));
    choice   = op;
    i0       = a;
    shift_by = n;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency and value, completes the handshake.
  task automatic collect(input string tag, input int exp_lat);
    int c = 1;
    logic [W-1:0] e;
    while (!out_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, W'(c), W'(exp_lat));
    chk({tag, "_out_valid"}, W'(out_valid), W'(1));
    chk({tag, "_in_ready_done"}, W'(in_ready), W'(0));
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, W'(0), W'(1));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_o"}, o, e);
    end
    if (out_ready) begin
      @(negedge clk);
      chk({tag, "_valid_clr"}, W'(out_valid), W'(0));
      chk({tag, "_in_ready_back"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    logic [1:0]   ops[4];
    logic [W-1:0] exp1[4];
    logic [W-1:0] exp4[4];
    logic [W-1:0] exp15[4];
    logic [W-1:0] held;
    ops   = '{OP_SLL, OP_SRL, OP_ROL, OP_ROR};
    exp1  = '{16'h000A, 16'h4002, 16'h000B, 16'hC002};
    exp4  = '{16'h0050, 16'h0800, 16'h0058, 16'h5800};
    exp15 = '{16'h8000, 16'h0001, 16'hC002, 16'h000B};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_o", o, 16'h0000);
    rst_n = 1'b1;
    chk("rel_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    chk("rel_in_ready_2", W'(in_ready), W'(1));

    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(ops[k], 16'h8005, 4'd1, exp1[k]);
      collect($sformatf("n1_op%0d", k), 2);
    end
    for (int k = 0; k < 4; k++) begin
      send(ops[k], 16'h8005, 4'd4, exp4[k]);
      collect($sformatf("n4_op%0d", k), 5);
    end
    for (int k = 0; k < 4; k++) begin
      send(ops[k], 16'h8005, 4'd15, exp15[k]);
      collect($sformatf("n15_op%0d", k), 16);
    end

    // Zero shift: result one cycle after acceptance, busy for that cycle only
    send(OP_ROR, 16'h8005, 4'd0, 16'h8005);
    chk("n0_busy", W'(busy), W'(1));
    collect("n0", 1);
    chk("n0_busy_after", W'(busy), W'(0));

    // Backpressure with noisy inputs during SHIFT and DONE
    out_ready = 1'b0;
    send(OP_SLL, 16'h1234, 4'd3, 16'h91A0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_shift_in_ready", W'(in_ready), W'(0));
      chk("bp_shift_busy", W'(busy), W'(1));
      in_valid = 1'($urandom_range(0, 1));
      i0 = W'($urandom_range(0, 16'hFFFF));
      choice = 2'($urandom_range(0, 3));
      shift_by = S'($urandom_range(0, 15));
      @(negedge clk);
    end
    chk("bp_out_valid", W'(out_valid), W'(1));
    held = exp_q.pop_front();
    chk("bp_o", o, held);
    for (int k = 0; k < 10; k++) begin
      in_valid = ~in_valid;
      i0 = W'($urandom_range(0, 16'hFFFF));
      @(negedge clk);
      chk("bp_hold_o", o, held);
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", W'(out_valid), W'(0));
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    chk("bp_o_kept", o, held);
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_extra_cmd", W'(busy), W'(0));
    end

    // Asynchronous reset in the middle of a shift
    send(OP_SLL, 16'hFFFF, 4'd12, 16'hF000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_pre", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_o", o, 16'h0000);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("mid_no_pulse", W'(out_valid), W'(0));
    end
    send(OP_ROR, 16'h0001, 4'd1, 16'h8000);
    collect("post_rst_ror", 2);
    chk("post_rst_o", o, 16'h8000);

    // Random commands against the barrel-shift model
    for (int k = 0; k < 24; k++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [S-1:0] rn;
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom_range(0, 16'hFFFF));
      rn  = S'($urandom_range(0, 15));
      send(rop, ra, rn, model(rop, ra, int'(rn)));
      collect($sformatf("rand%0d", k), (rn == 0) ? 1 : int'(rn) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
